// File: rtl/io_interval_timer_pkg.sv
// Shared definitions for the interval timer: register offsets (addr[3:2]),
// CTRL/STATUS bit positions and the 2-bit FSM state encoding.
package io_interval_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int STAT_PEND   = 0;
  localparam int STAT_OVF    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_REQ  = 2'd2,
    ST_ACKW = 2'd3
  } state_t;

endpackage

// File: rtl/io_interval_timer_handshake.sv
// Interrupt request/acknowledge handshake.
//   clk, rst   : clock, asynchronous active-high reset
//   req_pulse  : one-cycle expiry strobe from the counter
//   inta       : acknowledge from the CPU
//   intr       : registered interrupt request
//   busy       : a request is outstanding (REQ or ACKW)
// ST_IDLE here means "no request outstanding"; the counter's own run/idle
// status lives in the top (CTRL.EN). ST_RUN is never entered by this FSM.
module intr_handshake
  import io_interval_timer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_pulse,
  input  logic inta,
  output logic intr,
  output logic busy
);

  state_t r_state;
  state_t w_next;
  logic   r_intr;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_intr  <= 1'b0;
    end else begin
      r_state <= w_next;
      // intr is its own flop rather than a decode of r_state, so it cannot
      // glitch while the state bits change.
      r_intr  <= (w_next == ST_REQ);
    end
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_pulse) w_next = ST_REQ;
      ST_REQ:  if (inta)      w_next = ST_ACKW;
      ST_ACKW: if (!inta)     w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  assign intr = r_intr;
  assign busy = (r_state != ST_IDLE);

endmodule

// File: rtl/io_interval_timer.sv
// Memory-mapped interval timer on the CPU I/O bus.
//   clk, rst          : clock, asynchronous active-high reset
//   io_cs/io_wr/io_rd : I/O strobes shared with the I/O memory
//   addr[11:0]        : byte address; [11:4] block select, [3:2] register
//   din[31:0]         : write data
//   dout[31:0]        : read data, high-Z unless this block is being read
//   inta              : interrupt acknowledge
//   intr              : interrupt request
// Registers: CTRL (EN, RELOAD), LOAD, COUNT (read-only), STATUS (PEND, OVF,
// write-1-to-clear). The counter is running whenever CTRL.EN is set.
module io_interval_timer
  import io_interval_timer_pkg::*;
#(
  parameter logic [11:0] BASE = 12'h100,
  parameter int          CW   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_cs,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [11:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        inta,
  output logic        intr
);

  logic          r_en;
  logic          r_reload;
  logic [CW-1:0] r_load;
  logic [CW-1:0] r_count;
  logic          r_pend;
  logic          r_ovf;

  logic          w_hit;
  logic [1:0]    w_sel;
  logic          w_wr_ctrl;
  logic          w_wr_load;
  logic          w_wr_stat;
  logic          w_stop;
  logic          w_count_en;
  logic          w_expire;
  logic          w_keep;
  logic          w_start;
  logic          w_busy;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_hit     = io_cs & (addr[11:4] == BASE[11:4]);
  assign w_sel     = addr[3:2];
  assign w_unused  = &{1'b0, addr[1:0]};
  assign w_wr_ctrl = w_hit & io_wr & (w_sel == REG_CTRL);
  assign w_wr_load = w_hit & io_wr & (w_sel == REG_LOAD);
  assign w_wr_stat = w_hit & io_wr & (w_sel == REG_STATUS);

  // A CTRL write with EN=0 freezes COUNT on that very edge.
  assign w_stop     = w_wr_ctrl & ~din[CTRL_EN];
  assign w_count_en = r_en & ~w_stop;
  assign w_expire   = w_count_en & (r_count == CW'(1));
  // A zero reload value would wrap the counter, so treat it as one-shot.
  assign w_keep     = r_reload & (r_load != '0);
  // Start from stopped (or from a one-shot expiring on this same edge).
  assign w_start    = w_wr_ctrl & din[CTRL_EN] & (r_load != '0) &
                      (~r_en | (w_expire & ~w_keep));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_reload <= 1'b0;
      r_load   <= '0;
      r_count  <= '0;
      r_pend   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_count_en) begin
        if (w_expire) begin
          if (w_keep) begin
            r_count <= r_load;
          end else begin
            r_count <= '0;
            r_en    <= 1'b0;
          end
        end else begin
          r_count <= r_count - CW'(1);
        end
      end

      if (w_wr_ctrl) begin
        r_reload <= din[CTRL_RELOAD];
        if (!din[CTRL_EN]) begin
          r_en <= 1'b0;
        end else if (w_start) begin
          r_en    <= 1'b1;
          r_count <= r_load;
        end
      end

      if (w_wr_load) r_load <= din[CW-1:0];

      // Clear first, then set: a hardware event on the same edge wins.
      if (w_wr_stat) begin
        if (din[STAT_PEND]) r_pend <= 1'b0;
        if (din[STAT_OVF])  r_ovf  <= 1'b0;
      end
      if (w_expire) begin
        r_pend <= 1'b1;
        if (w_busy) r_ovf <= 1'b1;
      end
    end
  end

  // An expiry while a request is outstanding is not queued; it only
  // raises OVF above.
  intr_handshake u_handshake (
    .clk       (clk),
    .rst       (rst),
    .req_pulse (w_expire & ~w_busy),
    .inta      (inta),
    .intr      (intr),
    .busy      (w_busy)
  );

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_CTRL: begin
        w_rdata[CTRL_EN]     = r_en;
        w_rdata[CTRL_RELOAD] = r_reload;
      end
      REG_LOAD:  w_rdata = 32'(r_load);
      REG_COUNT: w_rdata = 32'(r_count);
      default: begin
        w_rdata[STAT_PEND] = r_pend;
        w_rdata[STAT_OVF]  = r_ovf;
      end
    endcase
  end

  assign dout = (w_hit & io_rd & ~io_wr) ? w_rdata : 'z;

endmodule

// File: tb/tb_io_interval_timer.sv
// Scoreboard bench for io_interval_timer: stimulus pushes expectations,
// a negedge monitor pops and compares whenever a probe is presented.
module tb_io_interval_timer;

  localparam logic [11:0] BASE   = 12'h100;
  localparam logic [11:0] A_CTRL = BASE + 12'h0;
  localparam logic [11:0] A_LOAD = BASE + 12'h4;
  localparam logic [11:0] A_CNT  = BASE + 12'h8;
  localparam logic [11:0] A_STAT = BASE + 12'hC;

  localparam int K_DOUT = 0;
  localparam int K_INTR = 1;
  localparam int K_Z    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_cs, io_wr, io_rd, inta;
  logic [11:0] addr;
  logic [31:0] din;
  wire  [31:0] dout;
  wire         intr;

  int          q_kind[$];
  logic [31:0] q_exp[$];
  logic [31:0] q_mask[$];
  string       q_name[$];

  int          errors = 0;
  int          checks = 0;
  logic        chk = 1'b0;

  int          m_kind;
  logic [31:0] m_exp, m_mask;
  string       m_name;

  io_interval_timer #(.BASE(BASE), .CW(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_cs (io_cs),
    .io_wr (io_wr),
    .io_rd (io_rd),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .inta  (inta),
    .intr  (intr)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per presented probe.
  always @(negedge clk) begin
    if (chk) begin
      checks++;
      if (q_kind.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: probe presented with empty queue");
      end else begin
        m_kind = q_kind.pop_front();
        m_exp  = q_exp.pop_front();
        m_mask = q_mask.pop_front();
        m_name = q_name.pop_front();
        if (m_kind == K_DOUT) begin
          if ((dout & m_mask) !== (m_exp & m_mask)) begin
            errors++;
            $display("FAIL %s: dout=%h expected %h (mask %h)", m_name, dout, m_exp, m_mask);
          end
        end else if (m_kind == K_INTR) begin
          if (intr !== m_exp[0]) begin
            errors++;
            $display("FAIL %s: intr=%b expected %b", m_name, intr, m_exp[0]);
          end
        end else begin
          if (dout !== 32'hzzzzzzzz) begin
            errors++;
            $display("FAIL %s: dout=%h expected high-Z", m_name, dout);
          end
        end
      end
    end
  end

  // Present one probe in the current cycle, then advance past the next edge.
  task automatic expect_item(input int kind, input logic [31:0] e,
                             input logic [31:0] m, input string name);
    q_kind.push_back(kind);
    q_exp.push_back(e);
    q_mask.push_back(m);
    q_name.push_back(name);
    chk = 1'b1;
    @(negedge clk);
    #1;
    chk   = 1'b0;
    io_cs = 1'b0;
    io_rd = 1'b0;
    io_wr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string name,
                    input logic [31:0] m = 32'hffffffff);
    io_cs = 1'b1; io_rd = 1'b1; io_wr = 1'b0; addr = a;
    expect_item(K_DOUT, e, m, name);
  endtask

  task automatic rd_z(input logic [11:0] a, input logic cs, input logic wr,
                      input string name);
    io_cs = cs; io_rd = 1'b1; io_wr = wr; addr = a; din = 32'h0bad_0bad;
    expect_item(K_Z, 32'h0, 32'h0, name);
  endtask

  task automatic probe(input logic e, input string name);
    expect_item(K_INTR, {31'b0, e}, 32'h1, name);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b0; addr = a; din = d;
    @(posedge clk);
    #1;
    io_cs = 1'b0; io_wr = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; io_cs = 0; io_wr = 0; io_rd = 0; inta = 0; addr = '0; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    rd(A_CTRL, 0, "rst ctrl");
    rd(A_LOAD, 0, "rst load");
    rd(A_CNT,  0, "rst count");
    rd(A_STAT, 0, "rst status");
    rd_z(A_CTRL, 1'b0, 1'b0, "rst dout z");
    probe(1'b0, "rst intr");

    // Reset in the middle of a request
    wr(A_LOAD, 4);
    wr(A_CTRL, 3);
    tick(2);
    rd(A_CNT, 2, "midrst count");
    probe(1'b0, "midrst pre");
    probe(1'b1, "midrst intr up");
    #2 rst = 1'b1;
    probe(1'b0, "midrst intr async");
    rst = 1'b0;
    rd(A_CTRL, 0, "midrst ctrl");
    rd(A_LOAD, 0, "midrst load");
    rd(A_CNT,  0, "midrst count0");
    rd(A_STAT, 0, "midrst status");
    rd_z(A_STAT, 1'b0, 1'b0, "midrst dout z");

    // One-shot: intr rises 5 edges after the enabling write
    wr(A_LOAD, 5);
    wr(A_CTRL, 1);
    for (int i = 0; i < 5; i++) probe(1'b0, "oneshot wait");
    probe(1'b1, "oneshot intr");
    rd(A_STAT, 1, "oneshot status");
    rd(A_CTRL, 0, "oneshot en cleared");
    rd(A_CNT,  0, "oneshot count");
    inta = 1'b1;
    probe(1'b1, "oneshot ack edge");
    probe(1'b0, "oneshot intr drop");
    inta = 1'b0;
    probe(1'b0, "oneshot ackw");
    tick(3);
    probe(1'b0, "oneshot idle");
    rd(A_CNT, 0, "oneshot count held");
    wr(A_STAT, 1);
    rd(A_STAT, 0, "oneshot pend clr");

    // LOAD = 1: expiry on the first edge; LOAD = 0: never starts
    wr(A_LOAD, 1);
    wr(A_CTRL, 1);
    probe(1'b0, "load1 pre");
    probe(1'b1, "load1 intr");
    inta = 1'b1; tick(1); inta = 1'b0; tick(1);
    wr(A_STAT, 3);
    wr(A_LOAD, 0);
    wr(A_CTRL, 1);
    tick(3);
    probe(1'b0, "load0 no intr");
    rd(A_STAT, 0, "load0 status");

    // Auto-reload: COUNT 3,2,1,3 with prompt acknowledges
    wr(A_LOAD, 3);
    wr(A_CTRL, 3);
    rd(A_CNT, 3, "reload cnt3");
    rd(A_CNT, 2, "reload cnt2");
    rd(A_CNT, 1, "reload cnt1");
    inta = 1'b1;
    probe(1'b1, "reload req1");
    inta = 1'b0;
    probe(1'b0, "reload ackw1");
    probe(1'b0, "reload idle1");
    inta = 1'b1;
    rd(A_CNT, 3, "reload cnt3b");
    inta = 1'b0;
    probe(1'b0, "reload ackw2");
    rd(A_STAT, 1, "reload no ovf");
    probe(1'b1, "reload req3");
    inta = 1'b1;
    wr(A_CTRL, 0);
    inta = 1'b0;
    probe(1'b0, "reload stopped");
    rd(A_CNT, 2, "reload count held");
    wr(A_STAT, 3);
    rd(A_STAT, 0, "reload status clr");

    // Overflow: inta withheld, single request, OVF sticky
    wr(A_LOAD, 2);
    wr(A_CTRL, 3);
    probe(1'b0, "ovf pre1");
    probe(1'b0, "ovf pre2");
    for (int i = 0; i < 9; i++) probe(1'b1, "ovf intr held");
    rd(A_STAT, 3, "ovf status");
    wr(A_STAT, 3);
    rd(A_STAT, 0, "ovf clear");
    probe(1'b1, "ovf intr still");
    wr(A_STAT, 3);
    rd(A_STAT, 2, "ovf set wins", 32'h2);
    inta = 1'b1;
    wr(A_CTRL, 0);
    inta = 1'b0;
    tick(1);
    probe(1'b0, "ovf done");
    wr(A_STAT, 3);
    rd(A_STAT, 0, "ovf final clr");

    // LOAD written while running applies at the next reload
    wr(A_LOAD, 3);
    wr(A_CTRL, 3);
    wr(A_LOAD, 5);
    rd(A_CNT, 2, "ldrun cnt2");
    rd(A_CNT, 1, "ldrun cnt1");
    rd(A_CNT, 5, "ldrun reload5");
    inta = 1'b1;
    wr(A_CTRL, 0);
    inta = 1'b0;
    tick(1);
    wr(A_STAT, 3);

    // Disable mid-run: COUNT frozen at 60
    wr(A_LOAD, 100);
    wr(A_CTRL, 1);
    tick(39);
    rd(A_CNT, 61, "dis cnt61");
    wr(A_CTRL, 0);
    for (int i = 0; i < 200; i++) probe(1'b0, "dis no intr");
    rd(A_CNT, 60, "dis frozen");
    rd(A_STAT, 0, "dis status");

    // Address decode
    rd_z(12'h0C4, 1'b1, 1'b0, "decode miss z");
    wr(12'h0C4, 32'hdead_beef);
    rd(A_LOAD, 100, "decode miss no write");
    wr(A_CNT, 32'h1234);
    rd(A_CNT, 60, "count ro");
    rd(BASE + 12'h7, 100, "load addr lsb ignored");
    rd_z(A_LOAD, 1'b1, 1'b1, "rd with wr z");

    @(negedge clk);
    #1;
    if (q_kind.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard drain: %0d expectations left, expected 0", q_kind.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
